// File: rtl/light_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : light_sequencer
// Brief    : Push-button conditioning and white/manual/auto mode FSM that
//            drives the colour-step pulse and white/RGB select line.
// Revision : 1.0 - initial release
// ============================================================================
module light_sequencer #(
    parameter int DEBOUNCE = 16,
    parameter int PERIOD   = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button,
    input  logic       auto_en,
    input  logic       white_req,
    output logic       step,
    output logic       sel,
    output logic [1:0] mode
);

    localparam int c_db_w = $clog2(DEBOUNCE + 1);
    localparam int c_tm_w = $clog2(PERIOD);
    localparam logic [c_db_w-1:0] c_db_last = c_db_w'(DEBOUNCE - 1);
    localparam logic [c_tm_w-1:0] c_tm_last = c_tm_w'(PERIOD - 1);

    typedef enum logic [1:0] {
        ST_WHITE  = 2'b00,
        ST_MANUAL = 2'b01,
        ST_AUTO   = 2'b10
    } state_t;

    logic              r_s1;
    logic              r_s2;
    logic [c_db_w-1:0] r_db_cnt;
    logic              r_db_level;
    logic              r_db_prev;
    logic [c_tm_w-1:0] r_timer;
    state_t            r_state;
    logic              r_sel;
    logic              r_step;
    logic              w_press;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= button;
            r_s2 <= r_s1;
        end
    end

    // Level flips only after DEBOUNCE consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_db_cnt   <= '0;
            r_db_level <= 1'b0;
            r_db_prev  <= 1'b0;
        end else begin
            r_db_prev <= r_db_level;
            if (r_s2 == r_db_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_db_last) begin
                r_db_level <= r_s2;
                r_db_cnt   <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign w_press = r_db_level & ~r_db_prev;

    // Timer defaults to 0 each edge, so it only advances while in AUTO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_WHITE;
            r_sel   <= 1'b0;
            r_step  <= 1'b0;
            r_timer <= '0;
        end else begin
            r_step  <= 1'b0;
            r_timer <= '0;
            if (white_req) begin
                r_state <= ST_WHITE;
                r_sel   <= 1'b0;
            end else begin
                case (r_state)
                    ST_WHITE: begin
                        if (w_press) begin
                            r_state <= auto_en ? ST_AUTO : ST_MANUAL;
                            r_sel   <= 1'b1;
                        end
                    end
                    ST_MANUAL: begin
                        r_sel <= 1'b1;
                        if (auto_en) begin
                            r_state <= ST_AUTO;
                        end else begin
                            r_step <= w_press;
                        end
                    end
                    ST_AUTO: begin
                        r_sel <= 1'b1;
                        if (!auto_en) begin
                            r_state <= ST_MANUAL;
                        end else if (w_press || (r_timer == c_tm_last)) begin
                            // A press coinciding with the wrap still yields one step.
                            r_step <= 1'b1;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_WHITE;
                        r_sel   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign step = r_step;
    assign sel  = r_sel;
    assign mode = r_state;

endmodule
`default_nettype wire
